// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline stage register with a 2-entry skid buffer, flush and vector payload.
// Control outputs are gated to zero on bubbles; data outputs hold their last value.
module ex_mem_pipe_reg #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ILEN    = 32,
    parameter int unsigned VLANES  = 4,
    parameter int unsigned VLANE_W = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      start_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [ILEN-1:0]           instr_i,
    input  logic                      zero_i,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic [VLANES*VLANE_W-1:0] valu_result_i,
    input  logic [XLEN-1:0]           rd_data_i,
    input  logic [RADDR_W-1:0]        rd_addr_i,
    input  logic [4:0]                ctrl_i,
    output logic [XLEN-1:0]           pc_o,
    output logic [ILEN-1:0]           instr_o,
    output logic                      zero_o,
    output logic [XLEN-1:0]           alu_result_o,
    output logic [VLANES*VLANE_W-1:0] valu_result_o,
    output logic [XLEN-1:0]           rd_data_o,
    output logic [RADDR_W-1:0]        rd_addr_o,
    output logic [4:0]                ctrl_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int unsigned VW = VLANES * VLANE_W;
    localparam int unsigned PW = XLEN + ILEN + 1 + XLEN + VW + XLEN + RADDR_W + 5;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [PW-1:0]    r_main;
    logic [PW-1:0]    r_skid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [PW-1:0]    w_in;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic             w_zero;
    logic [4:0]       w_ctrl;

    assign w_in = {pc_i, instr_i, zero_i, alu_result_i, valu_result_i,
                   rd_data_i, rd_addr_i, ctrl_i};

    // Ready is a pure state decode, so it never depends on out_ready_i.
    assign in_ready_o  = (r_state != FULL);
    assign out_valid_o = (r_state != EMPTY);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    always_comb begin
        w_state_d        = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush_i) begin
            w_state_d = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_main = 1'b1;
                        w_state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_d   = FULL;
                    end else if (w_pop) begin
                        w_state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_main_from_skid = 1'b1;
                        w_state_d        = BUSY;
                    end
                end
                default: w_state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_load_main) begin
                r_main <= w_in;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in;
            end
            if (out_valid_o && !out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign {pc_o, instr_o, w_zero, alu_result_o, valu_result_o,
            rd_data_o, rd_addr_o, w_ctrl} = r_main;

    assign zero_o      = out_valid_o & w_zero;
    assign ctrl_o      = out_valid_o ? w_ctrl : 5'b0;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg; a second instance with a 3-bit stall counter
// shares the inputs to exercise counter saturation.
module tb_ex_mem_pipe_reg;

    logic         clk_i = 1'b0;
    logic         start_i;
    logic         flush_i;
    logic         in_valid_i;
    logic [31:0]  pc_i;
    logic [31:0]  instr_i;
    logic         zero_i;
    logic [31:0]  alu_result_i;
    logic [127:0] valu_result_i;
    logic [31:0]  rd_data_i;
    logic [4:0]   rd_addr_i;
    logic [4:0]   ctrl_i;
    logic         out_ready_i;

    logic         in_ready_o;
    logic [31:0]  pc_o;
    logic [31:0]  instr_o;
    logic         zero_o;
    logic [31:0]  alu_result_o;
    logic [127:0] valu_result_o;
    logic [31:0]  rd_data_o;
    logic [4:0]   rd_addr_o;
    logic [4:0]   ctrl_o;
    logic         out_valid_o;
    logic [15:0]  stall_cnt_o;

    logic         s_in_ready_o;
    logic [31:0]  s_pc_o;
    logic [31:0]  s_instr_o;
    logic         s_zero_o;
    logic [31:0]  s_alu_result_o;
    logic [127:0] s_valu_result_o;
    logic [31:0]  s_rd_data_o;
    logic [4:0]   s_rd_addr_o;
    logic [4:0]   s_ctrl_o;
    logic         s_out_valid_o;
    logic [2:0]   s_stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_pipe_reg dut (
        .clk_i(clk_i), .start_i(start_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .zero_i(zero_i),
        .alu_result_i(alu_result_i), .valu_result_i(valu_result_i),
        .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
        .pc_o(pc_o), .instr_o(instr_o), .zero_o(zero_o),
        .alu_result_o(alu_result_o), .valu_result_o(valu_result_o),
        .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .ctrl_o(ctrl_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .stall_cnt_o(stall_cnt_o)
    );

    ex_mem_pipe_reg #(.CNT_W(3)) dut3 (
        .clk_i(clk_i), .start_i(start_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .zero_i(zero_i),
        .alu_result_i(alu_result_i), .valu_result_i(valu_result_i),
        .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
        .pc_o(s_pc_o), .instr_o(s_instr_o), .zero_o(s_zero_o),
        .alu_result_o(s_alu_result_o), .valu_result_o(s_valu_result_o),
        .rd_data_o(s_rd_data_o), .rd_addr_o(s_rd_addr_o), .ctrl_o(s_ctrl_o),
        .out_valid_o(s_out_valid_o), .out_ready_i(out_ready_i),
        .stall_cnt_o(s_stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        start_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        pc_i = '0; instr_i = '0; zero_i = 1'b0; alu_result_i = '0;
        valu_result_i = '0; rd_data_i = '0; rd_addr_i = '0; ctrl_i = '0;
        step(); step();
        chk("rst_out_valid", 128'(out_valid_o), 128'(0));
        chk("rst_in_ready", 128'(in_ready_o), 128'(1));
        chk("rst_pc", 128'(pc_o), 128'(0));
        start_i = 1'b1;
        step();

        // Stream with out_ready high
        out_ready_i = 1'b1; in_valid_i = 1'b1; pc_i = 32'h0;
        step();
        chk("str_valid0", 128'(out_valid_o), 128'(1));
        chk("str_pc0", 128'(pc_o), 128'(32'h0));
        pc_i = 32'h4;
        step();
        chk("str_valid1", 128'(out_valid_o), 128'(1));
        chk("str_pc1", 128'(pc_o), 128'(32'h4));
        pc_i = 32'h8;
        step();
        chk("str_valid2", 128'(out_valid_o), 128'(1));
        chk("str_pc2", 128'(pc_o), 128'(32'h8));
        in_valid_i = 1'b0;
        step();
        chk("str_drained", 128'(out_valid_o), 128'(0));

        // Backpressure into FULL, then drain in order
        out_ready_i = 1'b0; in_valid_i = 1'b1; pc_i = 32'h10;
        step();
        chk("bp_pc_a", 128'(pc_o), 128'(32'h10));
        chk("bp_ready_a", 128'(in_ready_o), 128'(1));
        pc_i = 32'h14;
        step();
        chk("bp_ready_full", 128'(in_ready_o), 128'(0));
        chk("bp_pc_hold", 128'(pc_o), 128'(32'h10));
        chk("bp_stall1", 128'(stall_cnt_o), 128'(1));
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk("bp_pc_b", 128'(pc_o), 128'(32'h14));
        chk("bp_ready_b", 128'(in_ready_o), 128'(1));
        chk("bp_valid_b", 128'(out_valid_o), 128'(1));
        step();
        chk("bp_empty", 128'(out_valid_o), 128'(0));

        // Flush while FULL drops the same-cycle accept
        out_ready_i = 1'b0; in_valid_i = 1'b1; ctrl_i = 5'b10101; pc_i = 32'h18;
        step();
        pc_i = 32'h1C;
        step();
        chk("fl_full", 128'(in_ready_o), 128'(0));
        chk("fl_ctrl_pre", 128'(ctrl_o), 128'(5'b10101));
        pc_i = 32'h20; flush_i = 1'b1;
        step();
        chk("fl_valid", 128'(out_valid_o), 128'(0));
        chk("fl_ctrl", 128'(ctrl_o), 128'(0));
        chk("fl_ready", 128'(in_ready_o), 128'(1));
        chk("fl_stall_kept", 128'(stall_cnt_o), 128'(3));
        flush_i = 1'b0; in_valid_i = 1'b0;
        step();
        chk("fl_no_ghost", 128'(out_valid_o), 128'(0));
        out_ready_i = 1'b1;
        step();
        chk("fl_no_ghost2", 128'(out_valid_o), 128'(0));

        // Payload pass-through and ctrl/zero gating
        in_valid_i = 1'b1; ctrl_i = 5'b11111; zero_i = 1'b1; pc_i = 32'h24;
        instr_i = 32'h0062_8233; alu_result_i = 32'hA5A5_0001;
        rd_data_i = 32'h1234_5678; rd_addr_i = 5'd17;
        valu_result_i = {32'hDEADBEEF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        step();
        chk("pl_ctrl", 128'(ctrl_o), 128'(5'b11111));
        chk("pl_zero", 128'(zero_o), 128'(1));
        chk("pl_instr", 128'(instr_o), 128'(32'h0062_8233));
        chk("pl_alu", 128'(alu_result_o), 128'(32'hA5A5_0001));
        chk("pl_rd_data", 128'(rd_data_o), 128'(32'h1234_5678));
        chk("pl_rd_addr", 128'(rd_addr_o), 128'(5'd17));
        chk("pl_valu", valu_result_o,
            {32'hDEADBEEF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        in_valid_i = 1'b0; ctrl_i = '0; zero_i = 1'b0; valu_result_i = '0;
        step();
        chk("gate_ctrl", 128'(ctrl_o), 128'(0));
        chk("gate_zero", 128'(zero_o), 128'(0));
        chk("gate_lane3", 128'(valu_result_o[96 +: 32]), 128'(32'hDEADBEEF));
        chk("gate_pc_hold", 128'(pc_o), 128'(32'h24));

        // Asynchronous reset while FULL
        out_ready_i = 1'b0; in_valid_i = 1'b1; ctrl_i = 5'b00011; pc_i = 32'h30;
        step();
        pc_i = 32'h34;
        step();
        chk("ar_full", 128'(in_ready_o), 128'(0));
        #2;
        start_i = 1'b0;
        #1;
        chk("ar_valid", 128'(out_valid_o), 128'(0));
        chk("ar_ctrl", 128'(ctrl_o), 128'(0));
        chk("ar_pc", 128'(pc_o), 128'(0));
        chk("ar_ready", 128'(in_ready_o), 128'(1));
        chk("ar_stall", 128'(stall_cnt_o), 128'(0));
        in_valid_i = 1'b0;
        step();
        start_i = 1'b1;
        step();

        // Stall counter and saturation
        in_valid_i = 1'b1; pc_i = 32'h40;
        step();
        in_valid_i = 1'b0;
        chk("sc_start", 128'(stall_cnt_o), 128'(0));
        repeat (5) step();
        chk("sc_five", 128'(stall_cnt_o), 128'(5));
        chk("sc3_five", 128'(s_stall_cnt_o), 128'(5));
        repeat (5) step();
        chk("sc_ten", 128'(stall_cnt_o), 128'(10));
        chk("sc3_sat", 128'(s_stall_cnt_o), 128'(7));
        out_ready_i = 1'b1;
        step();
        chk("sc_hold", 128'(stall_cnt_o), 128'(10));
        chk("sc_popped", 128'(out_valid_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
